// File: rtl/datapath_pkg.sv
// Shared datapath definitions: move-sequencer state encoding and default bank geometry.
package datapath_pkg;

    typedef enum logic [1:0] {
        MV_IDLE = 2'd0,
        MV_XFER = 2'd1,
        MV_DONE = 2'd2
    } mv_state_t;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_N_REGS = 16;

endpackage

// File: rtl/onehot_prio_enc.sv
// Priority encoder over a strobe vector: lowest set bit wins, plus any/multi flags.
module onehot_prio_enc #(
    parameter  int N     = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Scan downward so the lowest asserted bit is the last assignment.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

    assign any   = |vec;
    assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/reg_bank_bus.sv
// General register bank with priority bus source select and a register-to-register move sequencer.
// Optional R0_ZERO_EN: register 0 hardwired to zero, writes to it discarded.
//
// state   | meaning
// --------+----------------------------------------------------------------
// MV_IDLE | external strobes drive/load the bus; a move request is accepted
// MV_XFER | bus = reg[src_q], reg[dst_q] loads it; external strobes ignored
// MV_DONE | mv_done pulse, bus forced to 0; external strobes ignored
module reg_bank_bus
    import datapath_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int N_REGS = DEF_N_REGS,
    localparam int IDX_W  = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [N_REGS-1:0] reg_in,
    input  logic [N_REGS-1:0] reg_out,
    input  logic              ext_out,
    input  logic [WIDTH-1:0]  ext_data,
    output logic [WIDTH-1:0]  bus,
    input  logic              mv_valid,
    input  logic [IDX_W-1:0]  mv_src,
    input  logic [IDX_W-1:0]  mv_dst,
    output logic              mv_ready,
    output logic              mv_done,
    output logic              err,
    input  logic              err_clr
);

    mv_state_t         state, state_nxt;
    logic [WIDTH-1:0]  regs [N_REGS];
    logic [IDX_W-1:0]  src_q, dst_q;
    logic              oor_q;
    logic [IDX_W-1:0]  enc_idx, rd_idx;
    logic              enc_any, enc_multi;
    logic              rd_en, bus_ext, accept, mv_oor, err_set;
    logic [N_REGS-1:0] wr_en;
    logic [WIDTH-1:0]  rd_data;

    onehot_prio_enc #(.N(N_REGS)) u_rd_enc (
        .vec   (reg_out),
        .idx   (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    // Only reachable when N_REGS is not a power of two.
    assign mv_oor = (int'(mv_src) >= N_REGS) || (int'(mv_dst) >= N_REGS);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= MV_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mv_ready  = 1'b0;
        mv_done   = 1'b0;
        accept    = 1'b0;
        rd_en     = 1'b0;
        rd_idx    = enc_idx;
        bus_ext   = 1'b0;
        case (state)
            MV_IDLE: begin
                mv_ready = 1'b1;
                rd_en    = enc_any;
                bus_ext  = ext_out && !enc_any;
                if (mv_valid) begin
                    accept    = 1'b1;
                    state_nxt = MV_XFER;
                end
            end
            MV_XFER: begin
                rd_en     = !oor_q;
                rd_idx    = src_q;
                state_nxt = MV_DONE;
            end
            MV_DONE: begin
                mv_done   = 1'b1;
                state_nxt = MV_IDLE;
            end
            default: state_nxt = MV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            src_q <= '0;
            dst_q <= '0;
            oor_q <= 1'b0;
        end else if (accept) begin
            src_q <= mv_src;
            dst_q <= mv_dst;
            oor_q <= mv_oor;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = regs[i];
        end
    end

    always_comb begin
        bus = '0;
        if (rd_en)        bus = rd_data;
        else if (bus_ext) bus = ext_data;
    end

    always_comb begin
        wr_en = '0;
        if (state == MV_IDLE) begin
            wr_en = reg_in;
        end else if (state == MV_XFER && !oor_q) begin
            for (int i = 0; i < N_REGS; i++) begin
                if (dst_q == IDX_W'(i)) wr_en[i] = 1'b1;
            end
        end
`ifdef R0_ZERO_EN
        wr_en[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (wr_en[i]) regs[i] <= bus;
            end
        end
    end

    // Multi-drive and bad move indices only count while external strobes are live.
    assign err_set = (state == MV_IDLE) &&
                     (enc_multi || (enc_any && ext_out) || (mv_valid && mv_oor));

    always_ff @(posedge clk or posedge clr) begin
        if (clr)          err <= 1'b0;
        else if (err_set) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

endmodule

// File: tb/tb_reg_bank_bus.sv
// Self-checking bench for reg_bank_bus: directed scenarios plus randomized traffic against a register-array model.
module tb_reg_bank_bus;

    localparam int WIDTH = 32;
    localparam int N     = 16;
`ifdef R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clr;
    logic [N-1:0]     reg_in, reg_out;
    logic             ext_out;
    logic [WIDTH-1:0] ext_data;
    logic [WIDTH-1:0] bus;
    logic             mv_valid;
    logic [3:0]       mv_src, mv_dst;
    logic             mv_ready, mv_done, err;
    logic             err_clr;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] m_regs [N];
    logic             m_err;

    always #5 clk = ~clk;

    reg_bank_bus #(.WIDTH(WIDTH), .N_REGS(N)) dut (
        .clk      (clk),
        .clr      (clr),
        .reg_in   (reg_in),
        .reg_out  (reg_out),
        .ext_out  (ext_out),
        .ext_data (ext_data),
        .bus      (bus),
        .mv_valid (mv_valid),
        .mv_src   (mv_src),
        .mv_dst   (mv_dst),
        .mv_ready (mv_ready),
        .mv_done  (mv_done),
        .err      (err),
        .err_clr  (err_clr)
    );

    function automatic logic [WIDTH-1:0] exp_bus(input logic [N-1:0] ro, input logic eo,
                                                 input logic [WIDTH-1:0] ed);
        for (int i = 0; i < N; i++) if (ro[i]) return m_regs[i];
        if (eo) return ed;
        return '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reg_in = '0; reg_out = '0; ext_out = 1'b0; ext_data = '0;
        mv_valid = 1'b0; mv_src = '0; mv_dst = '0; err_clr = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_err = 1'b0;
    endtask

    task automatic drive_idle(input logic [N-1:0] ro, input logic [N-1:0] ri, input logic eo,
                              input logic [WIDTH-1:0] ed, input logic ec);
        reg_out = ro; reg_in = ri; ext_out = eo; ext_data = ed; err_clr = ec; mv_valid = 1'b0;
        #1;
    endtask

    // Advance one IDLE cycle, folding the currently driven strobes into the model.
    task automatic commit_idle();
        logic [WIDTH-1:0] b;
        bit multi;
        b = exp_bus(reg_out, ext_out, ext_data);
        multi = ($countones(reg_out) + int'(ext_out)) > 1;
        for (int i = 0; i < N; i++) if (reg_in[i] && !(R0_ZERO && i == 0)) m_regs[i] = b;
        if (multi) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        step();
        idle_inputs();
    endtask

    task automatic write_reg(input int idx, input logic [WIDTH-1:0] val);
        drive_idle('0, N'(1) << idx, 1'b1, val, 1'b0);
        commit_idle();
    endtask

    task automatic read_reg(input int idx, output logic [WIDTH-1:0] val);
        drive_idle(N'(1) << idx, '0, 1'b0, '0, 1'b0);
        val = bus;
        commit_idle();
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < N; i++) write_reg(i, $urandom);
        drive_idle(16'h0003, '0, 1'b0, '0, 1'b0);
        commit_idle();
        mv_valid = 1'b1; mv_src = 4'd3; mv_dst = 4'd4;
        step();
        mv_valid = 1'b0;
        clr = 1'b1;
        #1;
        step();
        clr = 1'b0;
        model_reset();
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (mv_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", mv_ready); end
        total++; if (mv_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", mv_done); end
        total++; if (bus !== '0) begin bad++; $display("FAIL reset_bus_idle: got %h want 0", bus); end
        for (int i = 0; i < N; i++) begin
            read_reg(i, v);
            total++; if (v !== '0) begin bad++; $display("FAIL reset_reg%0d: got %h want 0", i, v); end
        end
    endtask

    task automatic test_ext_write();
        logic [WIDTH-1:0] v;
        drive_idle('0, 16'h0020, 1'b1, 32'hDEADBEEF, 1'b0);
        total++; if (bus !== 32'hDEADBEEF) begin bad++; $display("FAIL ext_bus: got %h want deadbeef", bus); end
        commit_idle();
        read_reg(5, v);
        total++; if (v !== 32'hDEADBEEF) begin bad++; $display("FAIL ext_reg5: got %h want deadbeef", v); end
    endtask

    task automatic test_multi_drive();
        write_reg(3, 32'hA5A5_0003);
        write_reg(5, 32'h5A5A_0005);
        drive_idle('0, '0, 1'b0, '0, 1'b1);
        commit_idle();
        drive_idle(16'b0000_0000_0010_1000, '0, 1'b0, '0, 1'b0);
        total++; if (bus !== 32'hA5A5_0003) begin bad++; $display("FAIL multi_bus: got %h want a5a50003", bus); end
        commit_idle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL multi_err_set: got %b want 1", err); end
        drive_idle('0, '0, 1'b0, '0, 1'b0);
        commit_idle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL multi_err_sticky: got %b want 1", err); end
        drive_idle('0, '0, 1'b0, '0, 1'b1);
        commit_idle();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL multi_err_clr: got %b want 0", err); end
        drive_idle(16'h0008, '0, 1'b1, 32'h1111_1111, 1'b1);
        total++; if (bus !== 32'hA5A5_0003) begin bad++; $display("FAIL multi_reg_over_ext: got %h want a5a50003", bus); end
        commit_idle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL multi_set_wins: got %b want 1", err); end
        drive_idle('0, '0, 1'b1, 32'h2222_2222, 1'b1);
        total++; if (bus !== 32'h2222_2222) begin bad++; $display("FAIL multi_ext_only: got %h want 22222222", bus); end
        commit_idle();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL multi_single_src_no_err: got %b want 0", err); end
    endtask

    task automatic test_move();
        logic [WIDTH-1:0] v;
        write_reg(2, 32'h0000_1234);
        write_reg(4, 32'hCAFE_0004);
        write_reg(9, 32'h0BAD_0009);
        idle_inputs();
        mv_valid = 1'b1; mv_src = 4'd2; mv_dst = 4'd9;
        #1;
        total++; if (mv_ready !== 1'b1) begin bad++; $display("FAIL move_ready_T: got %b want 1", mv_ready); end
        step();
        mv_valid = 1'b0;
        reg_in = (N'(1) << 9) | (N'(1) << 4); reg_out = 16'h0001; ext_out = 1'b1; ext_data = 32'hFFFF_0000;
        #1;
        total++; if (bus !== 32'h0000_1234) begin bad++; $display("FAIL move_xfer_bus: got %h want 00001234", bus); end
        total++; if (mv_ready !== 1'b0) begin bad++; $display("FAIL move_ready_T1: got %b want 0", mv_ready); end
        total++; if (mv_done !== 1'b0) begin bad++; $display("FAIL move_done_T1: got %b want 0", mv_done); end
        step();
        m_regs[9] = 32'h0000_1234;
        #1;
        total++; if (mv_done !== 1'b1) begin bad++; $display("FAIL move_done_T2: got %b want 1", mv_done); end
        total++; if (mv_ready !== 1'b0) begin bad++; $display("FAIL move_ready_T2: got %b want 0", mv_ready); end
        total++; if (bus !== '0) begin bad++; $display("FAIL move_done_bus: got %h want 0", bus); end
        step();
        idle_inputs();
        #1;
        total++; if (mv_done !== 1'b0) begin bad++; $display("FAIL move_done_T3: got %b want 0", mv_done); end
        total++; if (mv_ready !== 1'b1) begin bad++; $display("FAIL move_ready_T3: got %b want 1", mv_ready); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL move_noise_err: got %b want 0", err); end
        read_reg(9, v);
        total++; if (v !== 32'h0000_1234) begin bad++; $display("FAIL move_dst: got %h want 00001234", v); end
        read_reg(4, v);
        total++; if (v !== 32'hCAFE_0004) begin bad++; $display("FAIL move_noise_write: got %h want cafe0004", v); end
    endtask

    task automatic test_clr_mid_move();
        logic [WIDTH-1:0] v;
        write_reg(1, 32'h7777_0001);
        write_reg(7, 32'h3333_0007);
        idle_inputs();
        mv_valid = 1'b1; mv_src = 4'd1; mv_dst = 4'd7;
        step();
        mv_valid = 1'b0;
        clr = 1'b1;
        #1;
        total++; if (mv_ready !== 1'b1) begin bad++; $display("FAIL clr_ready: got %b want 1", mv_ready); end
        total++; if (mv_done !== 1'b0) begin bad++; $display("FAIL clr_done0: got %b want 0", mv_done); end
        step();
        clr = 1'b0;
        model_reset();
        #1;
        total++; if (mv_done !== 1'b0) begin bad++; $display("FAIL clr_done1: got %b want 0", mv_done); end
        step();
        total++; if (mv_done !== 1'b0) begin bad++; $display("FAIL clr_done2: got %b want 0", mv_done); end
        total++; if (mv_ready !== 1'b1) begin bad++; $display("FAIL clr_ready2: got %b want 1", mv_ready); end
        read_reg(7, v);
        total++; if (v !== '0) begin bad++; $display("FAIL clr_dst: got %h want 0", v); end
    endtask

    task automatic test_r0();
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] want;
        want = R0_ZERO ? 32'h0 : 32'hFFFF_FFFF;
        write_reg(0, 32'hFFFF_FFFF);
        drive_idle(16'h0001, '0, 1'b1, 32'h1234_5678, 1'b0);
        v = bus;
        total++; if (v !== want) begin bad++; $display("FAIL r0_read: got %h want %h", v, want); end
        commit_idle();
    endtask

    task automatic test_random_idle();
        logic [N-1:0]     ro, ri;
        logic             eo, ec;
        logic [WIDTH-1:0] ed, want;
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0:       ro = '0;
                1:       ro = N'(1) << $urandom_range(0, N - 1);
                2:       ro = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
                default: ro = N'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0:       ri = N'($urandom);
                1:       ri = N'(1) << $urandom_range(0, N - 1);
                default: ri = '0;
            endcase
            eo = 1'($urandom);
            ed = $urandom;
            ec = ($urandom_range(0, 5) == 0);
            drive_idle(ro, ri, eo, ed, ec);
            want = exp_bus(ro, eo, ed);
            total++; if (bus !== want) begin bad++; $display("FAIL rnd_bus k=%0d: got %h want %h", k, bus, want); end
            commit_idle();
            total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err k=%0d: got %b want %b", k, err, m_err); end
        end
    endtask

    task automatic test_random_moves();
        int s, d;
        logic [WIDTH-1:0] val, v;
        drive_idle('0, '0, 1'b0, '0, 1'b1);
        commit_idle();
        for (int k = 0; k < 40; k++) begin
            s = $urandom_range(0, N - 1);
            d = (k % 5 == 0) ? s : $urandom_range(0, N - 1);
            if (k % 2 == 0) write_reg(s, $urandom);
            idle_inputs();
            mv_valid = 1'b1; mv_src = 4'(s); mv_dst = 4'(d);
            val = m_regs[s];
            step();
            mv_valid = 1'b0;
            reg_in = N'($urandom); reg_out = N'($urandom); ext_out = 1'b1; ext_data = $urandom;
            #1;
            total++; if (bus !== val) begin bad++; $display("FAIL rmv_xfer_bus k=%0d: got %h want %h", k, bus, val); end
            step();
            if (!(R0_ZERO && d == 0)) m_regs[d] = val;
            reg_in = N'($urandom); reg_out = N'($urandom);
            mv_valid = 1'b1; mv_src = 4'($urandom); mv_dst = 4'($urandom);
            #1;
            total++; if (mv_done !== 1'b1) begin bad++; $display("FAIL rmv_done k=%0d: got %b want 1", k, mv_done); end
            total++; if (bus !== '0) begin bad++; $display("FAIL rmv_done_bus k=%0d: got %h want 0", k, bus); end
            step();
            idle_inputs();
            #1;
            total++; if (mv_ready !== 1'b1) begin bad++; $display("FAIL rmv_ready k=%0d: got %b want 1", k, mv_ready); end
            total++; if (mv_done !== 1'b0) begin bad++; $display("FAIL rmv_done_low k=%0d: got %b want 0", k, mv_done); end
            read_reg(d, v);
            total++; if (v !== m_regs[d]) begin bad++; $display("FAIL rmv_dst k=%0d: got %h want %h", k, v, m_regs[d]); end
        end
        for (int i = 0; i < N; i++) begin
            read_reg(i, v);
            total++; if (v !== m_regs[i]) begin bad++; $display("FAIL rmv_final_reg%0d: got %h want %h", i, v, m_regs[i]); end
        end
        total++; if (err !== m_err) begin bad++; $display("FAIL rmv_err: got %b want %b", err, m_err); end
    endtask

    initial begin
        clr = 1'b1;
        idle_inputs();
        model_reset();
        step();
        step();
        clr = 1'b0;
        #1;
        test_reset();
        test_ext_write();
        test_multi_drive();
        test_move();
        test_clr_mid_move();
        test_r0();
        test_random_idle();
        test_random_moves();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
